// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode encodings, the fetch bubble opcode
// and the fetch-stage state encoding.
package proc_pkg;

    localparam logic [3:0] OP_LOAD    = 4'b0000;
    localparam logic [3:0] OP_STORE   = 4'b0001;
    localparam logic [3:0] OP_JUMP    = 4'b0010;
    localparam logic [3:0] OP_BRANCHZ = 4'b0100;
    localparam logic [3:0] OP_TYPEC   = 4'b1000;
    localparam logic [3:0] OP_ADDI    = 4'b1100;
    localparam logic [3:0] OP_SUBI    = 4'b1101;
    localparam logic [3:0] OP_ANDI    = 4'b1110;
    localparam logic [3:0] OP_ORI     = 4'b1111;

    // Undefined opcode: the control unit decodes it to all-zero controls.
    localparam logic [3:0] BUBBLE_OP  = 4'b0011;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ack port. imem_req is held until the cycle imem_ack
// is high; imem_rdata is taken only when imem_req && imem_ack on a clock edge.
interface fetch_unit_if #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 16
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: jump, branch-if-zero, increment or hold.
module pc_next #(
    parameter int ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    input  logic              jump_sel,
    input  logic              branch_sel,
    input  logic              zero,
    input  logic              pc_sel,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_off;

    assign pc_inc = pc + ADDR_W'(1);
    // Branch displacement is the low byte of the instruction, sign-extended.
    assign br_off = {{(ADDR_W-8){target[7]}}, target[7:0]};

    always_comb begin
        next_pc = pc;
        if (jump_sel) begin
            next_pc = target;
        end else if (branch_sel && zero) begin
            next_pc = pc_inc + br_off;
        end else if (branch_sel || pc_sel) begin
            next_pc = pc_inc;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, instruction register and the BOOT/FETCH/EXEC/HALT
// sequencer that fetches one word per instruction over the imem handshake.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    input  logic               ld_pc,
    input  logic               pc_sel,
    input  logic               jump_sel,
    input  logic               branch_sel,
    input  logic               zero,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output fetch_state_t       state
);
    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  pc_nxt;

    pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
        .pc         (pc_q),
        .target     (ir_q[ADDR_W-1:0]),
        .jump_sel   (jump_sel),
        .branch_sel (branch_sel),
        .zero       (zero),
        .pc_sel     (pc_sel),
        .next_pc    (pc_nxt)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            BOOT:  state_d = FETCH;
            FETCH: begin
                if (imem.imem_ack) begin
                    ir_d    = imem.imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (ld_pc) begin
                    pc_d    = pc_nxt;
                    state_d = FETCH;
                end else begin
                    state_d = HALT;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // All handshake/status outputs decode directly from the state register.
    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == EXEC);
    assign halted         = (state_q == HALT);
    assign opcode         = instr_valid ? ir_q[INSTR_W-1 -: 4] : BUBBLE_OP;
    assign instr          = ir_q;
    assign pc             = pc_q;
    assign state          = state_q;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit in the single-cycle processor. Holds the program counter, fetches one instruction word per step from a variable-latency instruction memory over a req/ack handshake, and presents the opcode to the control unit. Next-PC selection uses the control unit's `ldPC`, `pcSel`, `jumpSel` and `branchSel` outputs plus the ALU zero flag.

## Interface
- `ADDR_W`, 12: PC and instruction-memory address width.
- `INSTR_W`, 16: instruction width; opcode is `instr[INSTR_W-1 -: 4]`.
- `RESET_PC`, 0: PC value loaded on reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, held high until acknowledged.
- `imem_addr`  out  ADDR_W  fetch address; equals `pc` while `imem_req` is high.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  INSTR_W  instruction word, sampled when `imem_req && imem_ack`.
- `instr`  out  INSTR_W  instruction register (IR).
- `opcode`  out  4  to control unit; IR opcode when `instr_valid`, else `BUBBLE_OP` (4'b0011).
- `instr_valid`  out  1  IR holds the instruction currently executing.
- `ld_pc`, `pc_sel`, `jump_sel`, `branch_sel`  in  1 each  from control unit.
- `zero`  in  1  ALU zero flag for branch-if-zero.
- `pc`  out  ADDR_W  current PC.
- `halted`  out  1  stopped on an instruction that did not load PC.

## Operation
- States: BOOT, FETCH, EXEC, HALT. Reset forces BOOT.
- BOOT: one cycle, no request; then FETCH.
- FETCH: `imem_req=1`, `imem_addr=pc`. On an edge with `imem_ack=1`: IR <= `imem_rdata`, go to EXEC. Otherwise stay.
- EXEC: `instr_valid=1`; control inputs are sampled this cycle.
  - If `ld_pc=1`: update PC using the next-PC rule, then go to FETCH.
  - If `ld_pc=0`: go to HALT and leave PC unchanged.
- Next-PC rule, in priority order (all arithmetic modulo 2^ADDR_W):
  - `jump_sel`: `instr[ADDR_W-1:0]`.
  - `branch_sel && zero`: `pc + 1 + sext(instr[7:0])`.
  - `branch_sel && !zero`: `pc + 1`.
  - `pc_sel`: `pc + 1`.
  - None of the above: `pc` (no change).
- HALT: `halted=1`, `instr_valid=0`, no requests. Only reset exits HALT.
- Bubble: whenever `instr_valid=0`, `opcode=BUBBLE_OP`. This opcode is undefined, so the control unit drives every control output to 0 and no write occurs during a fetch.
- Control inputs are ignored outside EXEC. `imem_ack` is ignored outside FETCH.

## Timing
- Reset values: `pc=RESET_PC`, IR=0, `imem_req=0`, `instr_valid=0`, `opcode=BUBBLE_OP`, `halted=0`.
- `imem_req`, `instr_valid` and `halted` are decoded from registered state, so they are glitch-free. `opcode` is the IR field muxed by `instr_valid`.
- Zero-wait memory (ack in the first FETCH cycle) gives 2 cycles per instruction: FETCH, then EXEC. Each wait cycle adds one cycle.
- After `rst` deasserts, the first `imem_req` rises in the second cycle, because BOOT occupies the first.
- The PC update and the FETCH entry happen on the same edge. The new address appears on `imem_addr` in the cycle immediately after EXEC.
- Reset asserted mid-fetch: the request drops immediately, and an ack arriving in the same cycle is discarded. The memory must tolerate an abandoned request.
- PC wrap: `pc` at all-ones plus 1 gives 0, with no flag raised.

## Structure
- `proc_pkg` holds:
  - the opcode constants (LOAD 0000, STORE 0001, JUMP 0010, BRANCHZ 0100, TYPEC 1000, ADDI 1100, SUBI 1101, ANDI 1110, ORI 1111);
  - `BUBBLE_OP`;
  - the `fetch_state_t` enum.
- The control unit shares the opcode constants from `proc_pkg`.
- One combinational sub-module, `pc_next`, implements the next-PC rule; the FSM, PC and IR stay in `fetch_unit`.

## Test plan
- **Reset and boot:** hold `rst=0` for 3 cycles, then release.
  - During reset: `pc=0`, `imem_req=0`, `opcode=4'b0011`.
  - `imem_req` rises in the 2nd cycle after release, with `imem_addr=0`.
- **Sequential fetch:** zero-wait memory returns ADDI (`16'hC005`); bench drives `ld_pc=1`, `pc_sel=1` in EXEC.
  - `opcode=4'hC` for exactly one cycle; PC goes 0→1→2.
  - Fetches occur every 2 cycles.
- **Wait states:** ack delayed 3 cycles.
  - `imem_req` and `imem_addr` are held stable for 4 cycles.
  - IR is latched only on the ack edge; `opcode` stays `4'b0011` until then.
- **Jump and branch:**
  - At `pc=5`, JUMP `16'h2123` → next `imem_addr=12'h123`.
  - At `pc=10`, BRANCHZ `instr[7:0]=8'hFC`, `zero=1` → `pc=7`.
  - Same branch with `zero=0` → `pc=11`.
  - At `pc=12'hFFF`, `pc_sel` → `pc=0`.
- **Halt:** fetch opcode `4'b0011` with `ld_pc=0`.
  - `halted=1`, `imem_req` stays 0, `pc` unchanged.
  - Ack pulses are ignored.
  - Only `rst` restarts fetching from `RESET_PC`.
- **Reset mid-fetch:** assert `rst` during a FETCH wait, with ack arriving in the same cycle.
  - IR is not updated and `imem_req` drops asynchronously.
  - After release, fetch restarts at address 0.
